dac_slot_fifo: RTL and testbench

- Byte-wide circular buffer that feeds one DAC slot.
- Host/FX2 side writes audio bytes into it. The DAC module pulls them out with a read strobe and captures the data one cycle later.
- The read and write addresses are exported unchanged, so the DAC side can monitor fill level.
- Single clock domain. The DAC drives it with the same clk it runs on.

---
 rtl/dac_slot_fifo_if.sv | 28 ++
 rtl/dac_slot_fifo.sv | 87 ++++++++
 tb/tb_dac_slot_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dac_slot_fifo_if.sv
// rtl/dac_slot_fifo_if.sv - host/DAC side signal bundle for the DAC slot FIFO
interface dac_slot_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, addr_in, addr_out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, addr_in, addr_out, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/dac_slot_fifo.sv
// rtl/dac_slot_fifo.sv - byte circular buffer feeding one DAC slot, registered read port
module dac_slot_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic              clk,
  input  logic              reset,
  dac_slot_fifo_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  empty_w;
  logic                  full_w;
  logic                  rd_ok;
  logic                  wr_ok;

  assign empty_w = (cnt == '0);
  assign full_w  = cnt[ADDR_WIDTH];

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_ok = bus.rd_en && !empty_w;
  assign wr_ok = bus.wr_en && (!full_w || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok && !bus.flush) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else if (bus.flush) begin
      rd_data_q <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else if (bus.wr_en) begin
        ovf_q <= 1'b1;
      end

      // An empty read returns zero even if a write lands this same cycle.
      if (rd_ok) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_ONE;
      end else if (bus.rd_en) begin
        rd_data_q <= '0;
        unf_q     <= 1'b1;
      end

      if (wr_ok && !rd_ok) begin
        cnt <= cnt + CNT_ONE;
      end else if (rd_ok && !wr_ok) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.addr_in   = wr_ptr;
  assign bus.addr_out  = rd_ptr;
  assign bus.count     = cnt;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_dac_slot_fifo.sv
// tb/tb_dac_slot_fifo.sv - directed self-checking bench for dac_slot_fifo
module tb_dac_slot_fifo;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dac_slot_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(11)) bus ();

  dac_slot_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'((base + i) & 255);
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b1;

    // Reset state
    do_reset();
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_addr_in", 32'(bus.addr_in), 0);
    check("rst_addr_out", 32'(bus.addr_out), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_unf", 32'(bus.underflow), 0);

    // Four writes then a four-read burst
    fill(4, 8'h11);
    bus.wr_data = 8'h11; bus.wr_en = 1'b1; step();
    bus.wr_data = 8'h22; step();
    bus.wr_data = 8'h33; step();
    bus.wr_data = 8'h44; step();
    bus.wr_en = 1'b0;
    // Drain the 4 counting bytes (0x11..0x14) first
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("pre_rd", 32'(bus.rd_data), 32'(8'h11 + i));
    end
    bus.rd_en = 1'b0;
    check("burst_count4", 32'(bus.count), 4);
    bus.rd_en = 1'b1;
    step(); check("burst_rd0", 32'(bus.rd_data), 32'h11);
    step(); check("burst_rd1", 32'(bus.rd_data), 32'h22);
    step(); check("burst_rd2", 32'(bus.rd_data), 32'h33);
    step(); check("burst_rd3", 32'(bus.rd_data), 32'h44);
    bus.rd_en = 1'b0;
    step();
    check("burst_hold", 32'(bus.rd_data), 32'h44);
    check("burst_count0", 32'(bus.count), 0);
    check("burst_empty", 32'(bus.empty), 1);
    check("burst_addr_in", 32'(bus.addr_in), 8);
    check("burst_addr_out", 32'(bus.addr_out), 8);

    // Fill to full, drop one write, drain with wrap
    do_reset();
    fill(2048, 0);
    check("full_flag", 32'(bus.full), 1);
    check("full_count", 32'(bus.count), 2048);
    check("full_addr_in", 32'(bus.addr_in), 0);
    check("full_ovf0", 32'(bus.overflow), 0);
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE; step(); bus.wr_en = 1'b0;
    check("drop_ovf", 32'(bus.overflow), 1);
    check("drop_addr_in", 32'(bus.addr_in), 0);
    check("drop_count", 32'(bus.count), 2048);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      step();
      check("drain_rd", 32'(bus.rd_data), 32'(i & 255));
    end
    bus.rd_en = 1'b0;
    check("drain_addr_out", 32'(bus.addr_out), 0);
    check("drain_empty", 32'(bus.empty), 1);

    // Same-cycle read and write on empty: no bypass
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hA5; step();
    bus.wr_en = 1'b0;
    check("unf_flag", 32'(bus.underflow), 1);
    check("unf_rd_data", 32'(bus.rd_data), 0);
    check("unf_count", 32'(bus.count), 1);
    step();
    bus.rd_en = 1'b0;
    check("unf_next_rd", 32'(bus.rd_data), 32'hA5);
    check("unf_count0", 32'(bus.count), 0);

    // Full FIFO, simultaneous read and write for 10 cycles
    do_reset();
    fill(2048, 0);
    bus.rd_en = 1'b1; bus.wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_data = 8'(8'hC0 + i);
      step();
      check("rw_rd", 32'(bus.rd_data), 32'(i));
      check("rw_count", 32'(bus.count), 2048);
    end
    idle();
    check("rw_ovf", 32'(bus.overflow), 0);
    check("rw_addr_in", 32'(bus.addr_in), 10);
    check("rw_addr_out", 32'(bus.addr_out), 10);

    // Asynchronous reset mid-burst
    do_reset();
    fill(6, 8'h60);
    bus.rd_en = 1'b1; step(); step(); bus.rd_en = 1'b0;
    check("mid_count", 32'(bus.count), 4);
    check("mid_rd", 32'(bus.rd_data), 32'h61);
    #2 reset = 1'b0;
    #1;
    check("async_count", 32'(bus.count), 0);
    check("async_empty", 32'(bus.empty), 1);
    check("async_rd_data", 32'(bus.rd_data), 0);
    check("async_addr_in", 32'(bus.addr_in), 0);
    check("async_addr_out", 32'(bus.addr_out), 0);
    #1 reset = 1'b1;
    step();

    // Flush clears sticky flags and ignores a same-cycle write
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
    fill(2049, 0);
    check("pre_flush_ovf", 32'(bus.overflow), 1);
    check("pre_flush_unf", 32'(bus.underflow), 1);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h5A; step();
    idle();
    check("flush_count", 32'(bus.count), 0);
    check("flush_ovf", 32'(bus.overflow), 0);
    check("flush_unf", 32'(bus.underflow), 0);
    check("flush_addr_in", 32'(bus.addr_in), 0);
    check("flush_addr_out", 32'(bus.addr_out), 0);
    check("flush_empty", 32'(bus.empty), 1);
    fill(1, 8'h77);
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
    check("post_flush_rd", 32'(bus.rd_data), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
